// File: rtl/jtdd_adpcm_romarb.sv
// jtdd_adpcm_romarb: round-robin arbiter sharing one ADPCM ROM port between two cached channels
//   Ports: clk, rst (sync, active-high)
//          chN_addr/chN_cs in, chN_data/chN_ok out -- per-channel one-entry cache
//          rom_addr/rom_cs out, rom_data/rom_ok in  -- shared ROM slot, rom_addr MSB = grant
//   Optional macro JTDD_ROMARB_TOUT_EN: abort a fetch after TOUT WAIT cycles and cache 8'h88
module jtdd_adpcm_romarb #(
  parameter int AW   = 16,
  parameter int TOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] ch0_addr,
  input  logic          ch0_cs,
  output logic [7:0]    ch0_data,
  output logic          ch0_ok,
  input  logic [AW-1:0] ch1_addr,
  input  logic          ch1_cs,
  output logic [7:0]    ch1_data,
  output logic          ch1_ok,
  output logic [AW:0]   rom_addr,
  output logic          rom_cs,
  input  logic [7:0]    rom_data,
  input  logic          rom_ok
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t              state_q, state_d;
  logic                first_q, first_d;
  logic                grant_q, grant_d;
  logic                last_q, last_d;
  logic [AW-1:0]       req_q, req_d;
  logic                rom_cs_q, rom_cs_d;
  logic [AW:0]         rom_addr_q, rom_addr_d;
  logic [1:0]          valid_q, valid_d;
  logic [1:0][AW-1:0]  caddr_q, caddr_d;
  logic [1:0][7:0]     cdata_q, cdata_d;
  logic [1:0]          hit, miss;
  logic                pick, accept, tout;
  assign hit[0]   = valid_q[0] && caddr_q[0] == ch0_addr;
  assign hit[1]   = valid_q[1] && caddr_q[1] == ch1_addr;
  assign miss     = {ch1_cs, ch0_cs} & ~hit;
  assign pick     = &miss ? !last_q : miss[1];
  // the slot may still show the previous fetch's ok on the first WAIT cycle
  assign accept   = state_q == WAIT && !first_q && rom_ok;
  assign ch0_ok   = ch0_cs && hit[0];
  assign ch1_ok   = ch1_cs && hit[1];
  assign ch0_data = cdata_q[0];
  assign ch1_data = cdata_q[1];
  assign rom_cs   = rom_cs_q;
  assign rom_addr = rom_addr_q;
`ifdef JTDD_ROMARB_TOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       tout_flag_q, tout_flag_d;
  assign tout = state_q == WAIT && !accept && cnt_q == 8'(TOUT);
  always_comb begin
    cnt_d       = state_q == WAIT ? cnt_q + 8'd1 : 8'd0;
    tout_flag_d = tout_flag_q | tout;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      tout_flag_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      tout_flag_q <= tout_flag_d;
    end
  end
`else
  assign tout = 1'b0;
`endif
  always_comb begin
    state_d    = state_q;
    first_d    = 1'b0;
    grant_d    = grant_q;
    last_d     = last_q;
    req_d      = req_q;
    rom_cs_d   = rom_cs_q;
    rom_addr_d = rom_addr_q;
    valid_d    = valid_q;
    caddr_d    = caddr_q;
    cdata_d    = cdata_q;
    if (state_q == IDLE) begin
      if (|miss) begin
        grant_d    = pick;
        last_d     = pick;
        req_d      = pick ? ch1_addr : ch0_addr;
        rom_addr_d = {pick, req_d};
        rom_cs_d   = 1'b1;
        first_d    = 1'b1;
        state_d    = WAIT;
      end
    end else if (accept || tout) begin
      caddr_d[grant_q] = req_q;
      cdata_d[grant_q] = accept ? rom_data : 8'h88;
      valid_d[grant_q] = 1'b1;
      rom_cs_d         = 1'b0;
      state_d          = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      first_q    <= 1'b0;
      grant_q    <= 1'b0;
      last_q     <= 1'b1;
      req_q      <= '0;
      rom_cs_q   <= 1'b0;
      rom_addr_q <= '0;
      valid_q    <= '0;
      caddr_q    <= '0;
      cdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      first_q    <= first_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      req_q      <= req_d;
      rom_cs_q   <= rom_cs_d;
      rom_addr_q <= rom_addr_d;
      valid_q    <= valid_d;
      caddr_q    <= caddr_d;
      cdata_q    <= cdata_d;
    end
  end
endmodule

// File: tb/tb_jtdd_adpcm_romarb.sv
// tb_jtdd_adpcm_romarb: directed and random checks of the ROM arbiter against a transaction-level model
module tb_jtdd_adpcm_romarb;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] ch0_addr = '0, ch1_addr = '0;
  logic        ch0_cs = 1'b0, ch1_cs = 1'b0;
  logic [7:0]  ch0_data, ch1_data, rom_data = '0;
  logic        ch0_ok, ch1_ok, rom_cs, rom_ok = 1'b0;
  logic [16:0] rom_addr;
  int          checks = 0, errors = 0;
  bit          cmp_en = 0;
  bit          m_busy, m_last, m_g;
  int          m_age;
  logic [15:0] m_req;
  logic [16:0] m_raddr;
  bit          m_v[2];
  logic [15:0] m_ca[2];
  logic [7:0]  m_cd[2];

  jtdd_adpcm_romarb dut (
    .clk(clk), .rst(rst),
    .ch0_addr(ch0_addr), .ch0_cs(ch0_cs), .ch0_data(ch0_data), .ch0_ok(ch0_ok),
    .ch1_addr(ch1_addr), .ch1_cs(ch1_cs), .ch1_data(ch1_data), .ch1_ok(ch1_ok),
    .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_data(rom_data), .rom_ok(rom_ok)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_byte(input logic [16:0] a);
    return a[7:0] ^ a[15:8] ^ {a[16], 7'h0} ^ 8'hB5;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_step();
    bit mi0, mi1;
    if (rst) begin
      m_busy = 0; m_last = 1; m_g = 0; m_age = 0; m_req = '0; m_raddr = '0;
      for (int i = 0; i < 2; i++) begin m_v[i] = 0; m_ca[i] = '0; m_cd[i] = '0; end
    end else if (!m_busy) begin
      mi0 = ch0_cs && !(m_v[0] && m_ca[0] == ch0_addr);
      mi1 = ch1_cs && !(m_v[1] && m_ca[1] == ch1_addr);
      if (mi0 || mi1) begin
        m_g = (mi0 && mi1) ? !m_last : mi1;
        m_req = m_g ? ch1_addr : ch0_addr;
        m_last = m_g; m_busy = 1; m_age = 0; m_raddr = {m_g, m_req};
      end
    end else if (m_age > 0 && rom_ok) begin
      m_ca[m_g] = m_req; m_cd[m_g] = rom_byte({m_g, m_req}); m_v[m_g] = 1; m_busy = 0;
    end else m_age++;
  endtask

  task automatic tick();
    @(negedge clk);
    if (cmp_en) begin
      check("ok0", ch0_ok, ch0_cs && m_v[0] && m_ca[0] == ch0_addr);
      check("ok1", ch1_ok, ch1_cs && m_v[1] && m_ca[1] == ch1_addr);
      check("data0", ch0_data, m_cd[0]);
      check("data1", ch1_data, m_cd[1]);
      check("rom_cs", rom_cs, m_busy);
      check("rom_addr", rom_addr, m_raddr);
    end
    model_step();
    @(posedge clk);
    #1;
    rom_data = rom_byte(rom_addr);
    cmp_en = 1;
  endtask

  task automatic do_reset();
    rst = 1; tick(); tick(); rst = 0;
  endtask

  initial begin
    bit stuck = 0;
    do_reset();
    check("rst_cs", rom_cs, 0);
    check("rst_addr", rom_addr, 0);
    check("rst_data0", ch0_data, 0);
    // single fetch, rom_ok two cycles after rom_cs
    ch0_cs = 1; ch0_addr = 16'h0010; rom_ok = 0;
    tick();
    check("t1_cs", rom_cs, 1);
    check("t1_addr", rom_addr, 17'h00010);
    tick(); tick();
    rom_ok = 1; tick(); rom_ok = 0;
    check("t1_ok", ch0_ok, 1);
    check("t1_data", ch0_data, 8'hA5);
    check("t1_cs_low", rom_cs, 0);
    // simultaneous misses with rom_ok stuck high
    do_reset();
    ch0_addr = 16'h0100; ch1_addr = 16'h0200; ch0_cs = 1; ch1_cs = 1; rom_ok = 1;
    tick();
    check("t2_addr0", rom_addr, 17'h00100);
    tick();
    check("t2_stale_ok", ch0_ok, 0);
    tick();
    check("t2_ok0", ch0_ok, 1);
    check("t2_gap", rom_cs, 0);
    tick();
    check("t2_addr1", rom_addr, 17'h10200);
    tick(); tick();
    check("t2_ok1", ch1_ok, 1);
    ch0_addr = 16'h0101;
    tick(); tick(); tick();
    ch0_addr = 16'h0102; ch1_addr = 16'h0201;
    tick();
    check("t2_rr", rom_addr, 17'h10201);
    repeat (6) tick();
    // address change mid-fetch
    ch0_cs = 0; ch1_addr = 16'h0005; rom_ok = 0;
    tick();
    ch1_addr = 16'h0006;
    tick(); tick();
    rom_ok = 1; tick(); rom_ok = 0;
    check("t4_ok1", ch1_ok, 0);
    check("t4_cached", ch1_data, rom_byte(17'h10005));
    tick();
    check("t4_refetch", rom_addr, 17'h10006);
    rom_ok = 1; tick(); tick(); rom_ok = 0;
    // reset in the middle of a fetch
    ch0_cs = 1; ch0_addr = 16'h0020;
    tick();
    rst = 1; tick(); rst = 0; rom_ok = 1;
    check("t5_cs", rom_cs, 0);
    check("t5_ok0", ch0_ok, 0);
    check("t5_ok1", ch1_ok, 0);
    check("t5_data0", ch0_data, 0);
    tick(); rom_ok = 0;
    // without the timeout feature WAIT persists
    repeat (4) tick();
    ch0_addr = 16'h0030;
    repeat (300) tick();
    check("t6_wait", rom_cs, 1);
    check("t6_ok0", ch0_ok, 0);
    rom_ok = 1; tick(); tick(); rom_ok = 0;
    // random traffic
    for (int c = 0; c < 3000; c++) begin
      rst = $urandom_range(0, 299) == 0;
      if ($urandom_range(0, 49) == 0) stuck = !stuck;
      if ($urandom_range(0, 3) == 0) ch0_addr = 16'($urandom_range(0, 5));
      if ($urandom_range(0, 3) == 0) ch1_addr = 16'($urandom_range(0, 5));
      ch0_cs = $urandom_range(0, 7) != 0;
      ch1_cs = $urandom_range(0, 7) != 0;
      rom_ok = stuck || $urandom_range(0, 2) == 0;
      tick();
    end
    rst = 0;
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
